encoder_fsm_multi: RTL
======================

Name: encoder_fsm_multi

Overview:
- Parametrised successor to the single-block TX sequence checker in the PCS transmit path.
- Validates N_BLOCKS consecutive 64b/66b blocks per clock against the TX block-type state machine.
- Sits after the comparator/encoder and before the scrambler/distribution stage.
- Adds beyond the single-block version:
  - per-cycle chaining of the state machine across all lanes;
  - per-lane error flags;
  - a saturating error counter;
  - a bypass mode;
  - an output valid.

Parameters:
- NB_DATA_CODED, 66, width of one coded block.
- N_BLOCKS, 4, blocks processed per clock; range 1..8.
- NB_ERR_CNT, 16, width of the error counter.
- LBLOCK, 66'h2_4B00_0001_F000_0000, local-fault block driven after reset.
- EBLOCK, 66'h2_1E1E_1E1E_1E1E_1E1E, error block substituted on a sequence violation.

Ports:
- i_clock  in  1  clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_enable  in  1  global enable.
- i_valid  in  1  input blocks valid this cycle.
- i_bypass  in  1  1 = forward input data unaltered (checking and counting still active).
- i_clear_cnt  in  1  synchronous clear of o_err_count.
- i_tx_type  in  4*N_BLOCKS  per-lane type: D=1000, S=0100, C=0010, T=0001, E=0000.
- i_tx_coded  in  NB_DATA_CODED*N_BLOCKS  coded blocks; lane 0 in the LSBs, earliest in time.
- o_tx_coded  out  NB_DATA_CODED*N_BLOCKS  checked blocks.
- o_valid  out  1  o_tx_coded/o_err_flags valid.
- o_err_flags  out  N_BLOCKS  bit k = lane k was replaced (or would have been, in bypass).
- o_err_count  out  NB_ERR_CNT  saturating count of violating blocks.
- o_state  out  5  registered state after the last lane (debug).

Behaviour:
- Reset (asynchronous, i_reset=1):
  - every lane of o_tx_coded = LBLOCK;
  - o_valid=0, o_err_flags=0, o_err_count=0;
  - state = INIT.
- Accept condition: acc = i_enable && i_valid.
- Latency: 1 clock from an accepted input to o_tx_coded/o_valid/o_err_flags.
  - o_valid is the registered value of acc.
- States (one-hot): INIT=10000, C=01000, D=00100, T=00010, E=00001.
- Type decode: any i_tx_type value other than D, S, C or T is treated as E.
- Transition rules (s = state entering the lane, t = lane type):
  - INIT, C, T: t=C -> C; t=S -> D; else -> E.
  - D: t=D -> D; t=T -> T; else -> E.
  - E: t=T -> T; t=D -> D; t=C -> C; else (including S) -> E.
  - Any transition into E marks the lane as a violation.
- Lane chaining, all combinational within one cycle:
  - lane 0 uses the registered state;
  - lane k uses the next-state of lane k-1;
  - the next-state of lane N_BLOCKS-1 is registered on acc.
- Output data per lane:
  - violation and i_bypass=0 -> EBLOCK;
  - otherwise -> the input block.
- o_err_flags: registered violation vector on acc; forced to 0 on a non-accepted cycle.
- Counter, when acc:
  - o_err_count <= sat(base + popcount(violations)), where base = 0 if i_clear_cnt else o_err_count;
  - saturates at all-ones and never wraps.
- Counter, when not acc: i_clear_cnt alone clears it to 0.
- Non-accepted cycle (acc=0): state and o_tx_coded hold their values.
- i_bypass affects data substitution only; state, flags and counter behave identically in both modes.
- Reset mid-frame: state returns to INIT. The next lane must be C or S, otherwise it is a violation.

Test Plan:
- Reset, then accept 4 lanes of C:
  - after reset, before the first accept: o_tx_coded = 4xLBLOCK;
  - after the accept: output = input, o_err_flags=0000, o_state=01000, o_valid=1 one cycle later.
- Frame across two cycles:
  - inputs: S,D,D,D then D,D,T,C;
  - required: both cycles pass unaltered, flags 0, o_state=01000, o_err_count=0.
- Intra-cycle violation C,D,C,C starting from state C:
  - lane1 = EBLOCK; lanes 0, 2 and 3 pass;
  - o_err_flags=0010, o_err_count=1.
- Recovery from E: lanes S,D,T,E with state E entering lane 0:
  - lane0 is a violation (S from E) and stays E;
  - lane1 D -> D, lane2 T -> T, lane3 E is a violation;
  - flags=1001, count += 2.
- Stall and bypass:
  - i_valid=0 for 3 cycles: outputs and state hold, o_valid=0;
  - then i_bypass=1 with all-E types: data passes unaltered, flags=1111.
- Counter corners:
  - NB_ERR_CNT=4, 5 cycles of 4 errors: count = 15 and stays at 15;
  - i_clear_cnt together with 2 errors: count = 2.

Source files
------------

// File: rtl/encoder_fsm_multi.sv
// rtl/encoder_fsm_multi.sv - multi-lane 64b/66b TX block-type sequence checker
//
// Purpose: checks N_BLOCKS coded blocks per clock against the TX block-type
// state machine, chaining the state across the lanes within one cycle.
// Violating lanes are replaced by EBLOCK unless bypass is set.
//
// Ports:
//   i_clock, i_reset      clock, asynchronous active-high reset
//   i_enable, i_valid     a cycle is accepted when both are high
//   i_bypass              forward input data unaltered (checks still run)
//   i_clear_cnt           synchronous clear of the error counter
//   i_tx_type             4 bits per lane: D=1000 S=0100 C=0010 T=0001, else E
//   i_tx_coded            coded blocks, lane 0 in the LSBs (earliest)
//   o_tx_coded            checked blocks, 1 cycle latency
//   o_valid               registered accept
//   o_err_flags           per-lane violation flags
//   o_err_count           saturating violation count
//   o_state               one-hot state after the last lane

module encoder_fsm_multi #(
    parameter int                 NB_DATA_CODED = 66,
    parameter int                 N_BLOCKS      = 4,
    parameter int                 NB_ERR_CNT    = 16,
    parameter logic [NB_DATA_CODED-1:0] LBLOCK  = 66'h2_4B00_0001_F000_0000,
    parameter logic [NB_DATA_CODED-1:0] EBLOCK  = 66'h2_1E1E_1E1E_1E1E_1E1E
) (
    input  logic                              i_clock,
    input  logic                              i_reset,
    input  logic                              i_enable,
    input  logic                              i_valid,
    input  logic                              i_bypass,
    input  logic                              i_clear_cnt,
    input  logic [4*N_BLOCKS-1:0]             i_tx_type,
    input  logic [NB_DATA_CODED*N_BLOCKS-1:0] i_tx_coded,
    output logic [NB_DATA_CODED*N_BLOCKS-1:0] o_tx_coded,
    output logic                              o_valid,
    output logic [N_BLOCKS-1:0]               o_err_flags,
    output logic [NB_ERR_CNT-1:0]             o_err_count,
    output logic [4:0]                        o_state
);

    localparam logic [3:0] TYPE_D = 4'b1000;
    localparam logic [3:0] TYPE_S = 4'b0100;
    localparam logic [3:0] TYPE_C = 4'b0010;
    localparam logic [3:0] TYPE_T = 4'b0001;

    // Four spare bits hold the popcount of up to 8 lanes on top of a full counter.
    localparam int               SUM_W   = NB_ERR_CNT + 4;
    localparam logic [SUM_W-1:0] CNT_MAX = {4'b0000, {NB_ERR_CNT{1'b1}}};

    typedef enum logic [4:0] {
        ST_INIT = 5'b10000,
        ST_C    = 5'b01000,
        ST_D    = 5'b00100,
        ST_T    = 5'b00010,
        ST_E    = 5'b00001
    } state_t;

    state_t                              state_q, state_d;
    logic [NB_DATA_CODED*N_BLOCKS-1:0]   data_q, data_d;
    logic                                valid_q, valid_d;
    logic [N_BLOCKS-1:0]                 flags_q, flags_d;
    logic [NB_ERR_CNT-1:0]               cnt_q, cnt_d;

    logic                                acc;
    state_t                              lane_cur;
    state_t                              lane_nxt;
    logic [N_BLOCKS-1:0]                 viol;
    logic [NB_DATA_CODED*N_BLOCKS-1:0]   lane_data;
    logic [3:0]                          pop;
    logic [SUM_W-1:0]                    sum;
    logic [NB_ERR_CNT-1:0]               cnt_sat;

    // Unrecognised type codes fall through every branch and land in E.
    function automatic state_t next_state(input state_t s, input logic [3:0] t);
        state_t n;
        n = ST_E;
        case (s)
            ST_INIT, ST_C, ST_T: begin
                if (t == TYPE_C)      n = ST_C;
                else if (t == TYPE_S) n = ST_D;
            end
            ST_D: begin
                if (t == TYPE_D)      n = ST_D;
                else if (t == TYPE_T) n = ST_T;
            end
            ST_E: begin
                if (t == TYPE_T)      n = ST_T;
                else if (t == TYPE_D) n = ST_D;
                else if (t == TYPE_C) n = ST_C;
            end
            default: n = ST_E;
        endcase
        return n;
    endfunction

    assign acc = i_enable && i_valid;

    // Lane k enters with the state left by lane k-1; lane 0 with the register.
    always_comb begin
        lane_cur  = state_q;
        lane_nxt  = state_q;
        viol      = '0;
        lane_data = '0;
        pop       = '0;
        for (int k = 0; k < N_BLOCKS; k++) begin
            lane_nxt = next_state(lane_cur, i_tx_type[4*k +: 4]);
            viol[k]  = (lane_nxt == ST_E);
            lane_data[k*NB_DATA_CODED +: NB_DATA_CODED] =
                (viol[k] && !i_bypass) ? EBLOCK : i_tx_coded[k*NB_DATA_CODED +: NB_DATA_CODED];
            pop      = pop + {3'b000, viol[k]};
            lane_cur = lane_nxt;
        end
    end

    always_comb begin
        sum     = (i_clear_cnt ? '0 : SUM_W'(cnt_q)) + SUM_W'(pop);
        cnt_sat = (sum > CNT_MAX) ? '1 : sum[NB_ERR_CNT-1:0];

        state_d = acc ? lane_cur  : state_q;
        data_d  = acc ? lane_data : data_q;
        valid_d = acc;
        flags_d = acc ? viol : '0;
        if (acc)              cnt_d = cnt_sat;
        else if (i_clear_cnt) cnt_d = '0;
        else                  cnt_d = cnt_q;
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_INIT;
            data_q  <= {N_BLOCKS{LBLOCK}};
            valid_q <= 1'b0;
            flags_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_tx_coded  = data_q;
    assign o_valid     = valid_q;
    assign o_err_flags = flags_q;
    assign o_err_count = cnt_q;
    assign o_state     = state_q;

endmodule
